aes_run_controller: RTL and testbench
=====================================

# aes_run_controller

Sequencer for the AES-128/192/256 encrypt/decrypt round-trip in the board top.
- Replaces the free-running cycle counter with an explicit FSM:
  - selects the key size;
  - releases the `Encrypt` cores from reset;
  - enables the matching `Decrypt` core after the encryption latency;
  - captures ciphertext and recovered plaintext;
  - reports pass/fail against the original plaintext.
- Its `data_out` feeds the Encoder/Decoder HEX display path.
- `pass` drives LEDR[0].

## Interface
Parameters:
- `NR_128`, default 10: rounds for 128-bit key.
- `NR_192`, default 12: rounds for 192-bit key.
- `NR_256`, default 14: rounds for 256-bit key.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  level sampled each edge; starts a run from IDLE or DONE.
- `key_sel`  in  3  one-hot key size: bit0 = 128, bit1 = 192, bit2 = 256.
- `plaintext`  in  128  reference state, also the value fed to the Encrypt cores.
- `enc_data`  in  128  output of the Encrypt core selected by `mode`.
- `dec_data`  in  128  output of the Decrypt core selected by `mode`.
- `mode`  out  2  latched size: 00 = 128, 01 = 192, 10 = 256; mux select for `enc_data`/`dec_data`.
- `enc_reset`  out  1  reset to all Encrypt cores; high except in ENC.
- `dec_enable`  out  3  one-hot enable to the Decrypt cores; high only in DEC.
- `cipher_q`  out  128  captured ciphertext.
- `data_out`  out  128  display value.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete.
- `pass`  out  1  recovered plaintext equals `plaintext`.
- `err`  out  1  one-cycle pulse: `start` seen with a non-one-hot `key_sel`.

## Operation
- States: IDLE, ENC, DEC, CHECK, DONE. Counter `cnt` is 5 bits. `nr` is taken from `mode`.
- **IDLE / DONE**, on `start`:
  - If `key_sel` is one-hot: latch `mode`, clear `cnt`, clear `pass` and `done`, go to ENC.
  - If `key_sel` is not one-hot: pulse `err`, stay in the current state.
  - With `start` low: hold the current state.
- **ENC**:
  - `enc_reset` is 0. `cnt` increments each cycle.
  - When `cnt == nr+1`: `cipher_q <= enc_data`, `cnt <= 0`, go to DEC.
- **DEC**:
  - `dec_enable[mode]` is 1.
  - When `cnt == nr+1`: `plain_q <= dec_data`, go to CHECK.
- **CHECK**: `pass <= (plain_q == plaintext)`, go to DONE.
- **DONE**: `done` is 1, `enc_reset` is 1, `dec_enable` is 0. Outputs hold until `start` or `reset`.
- `start` is ignored in ENC, DEC and CHECK.
- `data_out` is a combinational mux on state:
  - IDLE: `plaintext`
  - ENC: `enc_data`
  - DEC: `dec_data`
  - CHECK/DONE: `plain_q`
- `busy` is high in ENC, DEC and CHECK.
- Reset values: state IDLE, `cnt` 0, `mode` 00, `enc_reset` 1, `dec_enable` 000, `cipher_q` 0, `plain_q` 0, `busy` 0, `done` 0, `pass` 0, `err` 0, `data_out` = `plaintext`.

## Timing
- Edge E0 samples `start`. Edges E1..E(nr+2) are ENC. The ciphertext capture happens at E(nr+2).
- DEC occupies E(nr+3)..E(2nr+4). CHECK is E(2nr+5). After E(2nr+5), `done` and `pass` are valid.
  - 128-bit: 25 edges.
  - 192-bit: 29 edges.
  - 256-bit: 33 edges.
- `busy` rises after E0 and falls together with the rise of `done`.
- `err` is high for exactly one cycle after the offending edge.
- Reset mid-run: at the next edge go to IDLE with all reset values. Nothing captured survives.
- `start` held high in DONE immediately begins a new run. `done` drops after that edge.
- `key_sel` changes during a run have no effect; `mode` is latched at start.
- `cnt` never exceeds `nr+1` (max 15); 5 bits gives margin.

## Structure
- Package `aes_ctrl_pkg`:
  - state enum (IDLE, ENC, DEC, CHECK, DONE);
  - mode encodings;
  - `NR_*` and `NK_*` localparams;
  - function `nr_of(mode)`;
  - function `onehot3(key_sel)`.
- Single module, no sub-module. The 128-bit compare is inline.
- The top instantiates this block and performs the `mode`-indexed mux of the three Encrypt/Decrypt outputs into `enc_data`/`dec_data`.

## Test plan
All runs use `plaintext = 00112233445566778899aabbccddeeff` and FIPS-197 keys.
- **128-bit run**: `key_sel` = 001, `start` for 1 cycle.
  - `cipher_q = 69c4e0d86a7b0430d8cdb78070b4c55a` at E12.
  - `done = 1`, `pass = 1` after E25.
  - `data_out = plaintext` in DONE.
- **192-bit run**: `key_sel` = 010.
  - `cipher_q = dda97ca4864cdfe06eaf70a0ec0d7191`.
  - `done` after E29, `pass = 1`.
- **256-bit run**: `key_sel` = 100.
  - `cipher_q = 8ea2b7ca516745bfeafc49904b496089`.
  - `done` after E33, `pass = 1`.
- **Illegal select**: `key_sel` = 011 or 000 with `start`.
  - `err` is high for 1 cycle; state stays IDLE; `busy` stays 0.
- **Reset mid-run**: `reset` at E8 of a 128-bit run.
  - Next cycle: IDLE, `enc_reset = 1`, `dec_enable = 000`, `cipher_q = 0`.
  - A subsequent 128-bit run passes.
- **Forced mismatch and restart**:
  - Corrupt `dec_data` bit 0 in DEC: `pass = 0` after `done`.
  - Restarting from DONE clears `done` and `pass` after E0; the new run passes.
  - `start` pulsed mid-run is ignored.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared constants and helpers for the AES round-trip run controller.
package aes_ctrl_pkg;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 3;

    // Sequencer states
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ENC   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    // Latched key-size encodings; also the core mux select
    localparam logic [MODE_W-1:0] MODE_128 = 2'b00;
    localparam logic [MODE_W-1:0] MODE_192 = 2'b01;
    localparam logic [MODE_W-1:0] MODE_256 = 2'b10;

    // Round counts and key lengths in 32-bit words
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;
    localparam int unsigned NK_128 = 4;
    localparam int unsigned NK_192 = 6;
    localparam int unsigned NK_256 = 8;

    // Default round count for a mode
    function automatic logic [CNT_W-1:0] nr_of(input logic [MODE_W-1:0] mode);
        case (mode)
            MODE_192: return CNT_W'(NR_192);
            MODE_256: return CNT_W'(NR_256);
            default:  return CNT_W'(NR_128);
        endcase
    endfunction

    // True when exactly one of the three key-size bits is set
    function automatic logic onehot3(input logic [SEL_W-1:0] key_sel);
        return (key_sel == 3'b001) || (key_sel == 3'b010) || (key_sel == 3'b100);
    endfunction

    // One-hot key select to mode encoding (caller guarantees one-hot)
    function automatic logic [MODE_W-1:0] mode_of(input logic [SEL_W-1:0] key_sel);
        case (key_sel)
            3'b010:  return MODE_192;
            3'b100:  return MODE_256;
            default: return MODE_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_run_controller.sv
// Sequences one AES encrypt/decrypt round trip and checks the recovered plaintext.
module aes_run_controller #(
    parameter int unsigned NR_128 = 10,
    parameter int unsigned NR_192 = 12,
    parameter int unsigned NR_256 = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   key_sel,
    input  logic [127:0] plaintext,
    input  logic [127:0] enc_data,
    input  logic [127:0] dec_data,
    output logic [1:0]   mode,
    output logic         enc_reset,
    output logic [2:0]   dec_enable,
    output logic [127:0] cipher_q,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         err
);
    import aes_ctrl_pkg::*;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [DATA_W-1:0]  cipher_d;
    logic [DATA_W-1:0]  plain_q, plain_d;
    logic               enc_reset_q, enc_reset_d;
    logic [SEL_W-1:0]   dec_enable_q, dec_enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_last;

    // Last count value of a phase: nr+1 for the latched key size
    always_comb begin
        case (mode_q)
            MODE_192: cnt_last = CNT_W'(NR_192 + 1);
            MODE_256: cnt_last = CNT_W'(NR_256 + 1);
            default:  cnt_last = CNT_W'(NR_128 + 1);
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mode_q       <= MODE_128;
            cipher_q     <= '0;
            plain_q      <= '0;
            enc_reset_q  <= 1'b1;
            dec_enable_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            cipher_q     <= cipher_d;
            plain_q      <= plain_d;
            enc_reset_q  <= enc_reset_d;
            dec_enable_q <= dec_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic; output registers follow the next state so they line up with it
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        cipher_d = cipher_q;
        plain_d  = plain_q;
        pass_d   = pass_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (onehot3(key_sel)) begin
                        mode_d  = mode_of(key_sel);
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                        state_d = ST_ENC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ENC: begin
                if (cnt_q == cnt_last) begin
                    cipher_d = enc_data;
                    cnt_d    = '0;
                    state_d  = ST_DEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEC: begin
                if (cnt_q == cnt_last) begin
                    plain_d = dec_data;
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                pass_d  = (plain_q == plaintext);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d == ST_ENC) || (state_d == ST_DEC) || (state_d == ST_CHECK);
        done_d       = (state_d == ST_DONE);
        enc_reset_d  = (state_d != ST_ENC);
        dec_enable_d = (state_d == ST_DEC) ? (3'b001 << mode_d) : 3'b000;
    end

    // Display value follows whichever stage is active
    always_comb begin
        case (state_q)
            ST_IDLE: data_out = plaintext;
            ST_ENC:  data_out = enc_data;
            ST_DEC:  data_out = dec_data;
            default: data_out = plain_q;
        endcase
    end

    assign mode       = mode_q;
    assign enc_reset  = enc_reset_q;
    assign dec_enable = dec_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err        = err_q;

endmodule

// File: tb/tb_aes_run_controller.sv
// Bench for aes_run_controller with latency-accurate stand-ins for the AES cores.
module tb_aes_run_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   key_sel;
    logic [127:0] plaintext;
    logic [127:0] enc_data;
    logic [127:0] dec_data;
    logic [1:0]   mode;
    logic         enc_reset;
    logic [2:0]   dec_enable;
    logic [127:0] cipher_q;
    logic [127:0] data_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] FIPS_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_run_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_sel    (key_sel),
        .plaintext  (plaintext),
        .enc_data   (enc_data),
        .dec_data   (dec_data),
        .mode       (mode),
        .enc_reset  (enc_reset),
        .dec_enable (dec_enable),
        .cipher_q   (cipher_q),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err        (err)
    );

    // Core stand-ins: result is valid only on the cycle nr+1 edges after release
    logic [127:0] cipher_ref = '0;
    int           env_nr     = 10;
    logic [1:0]   env_mode   = 2'd0;
    logic         corrupt    = 1'b0;
    logic [127:0] garbage    = '0;
    int           enc_cnt    = 0;
    int           dec_cnt    = 0;

    always @(posedge clk) begin
        garbage <= {$urandom, $urandom, $urandom, $urandom};
        enc_cnt <= enc_reset ? 0 : enc_cnt + 1;
        dec_cnt <= dec_enable[env_mode] ? dec_cnt + 1 : 0;
    end

    always_comb begin
        enc_data = (enc_cnt == env_nr + 1) ? cipher_ref : garbage;
        dec_data = (dec_cnt == env_nr + 1) ? (plaintext ^ {127'b0, corrupt}) : garbage;
    end

    // Full run from E0 to the DONE edge, checking every cycle against the timing rules
    task automatic do_run(input logic [2:0] ks, input logic [127:0] pt, input logic [127:0] ct,
                          input logic bad, input int pulse_at, input string tag);
        int          nr;
        logic [1:0]  m;
        logic [127:0] exp_plain;
        logic        ph_enc, ph_dec, ph_chk, ph_done;
        logic        e_busy, e_done, e_encr, e_pass;
        logic [2:0]  e_dec;
        logic [127:0] e_out;
        m          = ks[0] ? 2'd0 : (ks[1] ? 2'd1 : 2'd2);
        nr         = 10 + 2 * int'(m);
        env_mode   = m;
        env_nr     = nr;
        cipher_ref = ct;
        corrupt    = bad;
        plaintext  = pt;
        exp_plain  = pt ^ {127'b0, bad};
        for (int k = 0; k <= 2 * nr + 5; k++) begin
            if (k == 0) begin
                start   = 1'b1;
                key_sel = ks;
            end else begin
                start   = (k == pulse_at);
                key_sel = 3'($urandom);
            end
            @(posedge clk);
            #1;
            ph_enc  = (k <= nr + 1);
            ph_dec  = (k >= nr + 2) && (k <= 2 * nr + 3);
            ph_chk  = (k == 2 * nr + 4);
            ph_done = (k == 2 * nr + 5);
            e_busy  = !ph_done;
            e_done  = ph_done;
            e_encr  = !ph_enc;
            e_dec   = ph_dec ? (3'b001 << m) : 3'b000;
            e_pass  = ph_done ? !bad : 1'b0;
            e_out   = ph_enc ? enc_data : (ph_dec ? dec_data : exp_plain);
            n_checks++;
            if (busy !== e_busy) begin
                n_fail++; $display("FAIL %s.busy k=%0d got %b want %b", tag, k, busy, e_busy);
            end
            n_checks++;
            if (done !== e_done) begin
                n_fail++; $display("FAIL %s.done k=%0d got %b want %b", tag, k, done, e_done);
            end
            n_checks++;
            if (enc_reset !== e_encr) begin
                n_fail++; $display("FAIL %s.enc_reset k=%0d got %b want %b", tag, k, enc_reset, e_encr);
            end
            n_checks++;
            if (dec_enable !== e_dec) begin
                n_fail++; $display("FAIL %s.dec_enable k=%0d got %b want %b", tag, k, dec_enable, e_dec);
            end
            n_checks++;
            if (pass !== e_pass) begin
                n_fail++; $display("FAIL %s.pass k=%0d got %b want %b", tag, k, pass, e_pass);
            end
            n_checks++;
            if (mode !== m) begin
                n_fail++; $display("FAIL %s.mode k=%0d got %b want %b", tag, k, mode, m);
            end
            n_checks++;
            if (err !== 1'b0) begin
                n_fail++; $display("FAIL %s.err k=%0d got %b want 0", tag, k, err);
            end
            n_checks++;
            if (data_out !== e_out) begin
                n_fail++; $display("FAIL %s.data_out k=%0d got %h want %h", tag, k, data_out, e_out);
            end
            if (k >= nr + 2) begin
                n_checks++;
                if (cipher_q !== ct) begin
                    n_fail++; $display("FAIL %s.cipher_q k=%0d got %h want %h", tag, k, cipher_q, ct);
                end
            end
        end
        start   = 1'b0;
        key_sel = 3'b000;
    endtask

    task automatic test_reset();
        plaintext = FIPS_PT;
        reset     = 1'b1;
        start     = 1'b0;
        key_sel   = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({mode, enc_reset, dec_enable, busy, done, pass, err} !== {2'b00, 1'b1, 3'b000, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset.ctrl got mode=%b encr=%b dec=%b busy=%b done=%b pass=%b err=%b",
                     mode, enc_reset, dec_enable, busy, done, pass, err);
        end
        n_checks++;
        if (cipher_q !== 128'h0) begin
            n_fail++; $display("FAIL reset.cipher_q got %h want 0", cipher_q);
        end
        n_checks++;
        if (data_out !== FIPS_PT) begin
            n_fail++; $display("FAIL reset.data_out got %h want %h", data_out, FIPS_PT);
        end
        reset = 1'b0;
    endtask

    task automatic test_fips_runs();
        do_run(3'b001, FIPS_PT, FIPS_128, 1'b0, 0, "run128");
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({done, pass, busy} !== 3'b110 || data_out !== FIPS_PT) begin
                n_fail++; $display("FAIL run128.hold got done=%b pass=%b busy=%b out=%h", done, pass, busy, data_out);
            end
        end
        do_run(3'b010, FIPS_PT, FIPS_192, 1'b0, 0, "run192");
        do_run(3'b100, FIPS_PT, FIPS_256, 1'b0, 0, "run256");
    endtask

    task automatic test_illegal_select();
        logic [2:0] bad_sel[4] = '{3'b011, 3'b000, 3'b111, 3'b101};
        logic       was_done;
        logic       was_pass;
        for (int i = 0; i < 4; i++) begin
            was_done = done;
            was_pass = pass;
            key_sel  = bad_sel[i];
            start    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n_checks++;
            if (err !== 1'b1 || busy !== 1'b0 || enc_reset !== 1'b1) begin
                n_fail++; $display("FAIL illegal.pulse sel=%b got err=%b busy=%b encr=%b want 1 0 1", bad_sel[i], err, busy, enc_reset);
            end
            n_checks++;
            if (done !== was_done || pass !== was_pass) begin
                n_fail++; $display("FAIL illegal.hold sel=%b got done=%b pass=%b want %b %b", bad_sel[i], done, pass, was_done, was_pass);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL illegal.clear sel=%b got err=%b busy=%b want 0 0", bad_sel[i], err, busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        env_mode   = 2'd0;
        env_nr     = 10;
        cipher_ref = FIPS_128;
        corrupt    = 1'b0;
        plaintext  = FIPS_PT;
        key_sel    = 3'b001;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, done, pass, enc_reset, dec_enable, mode} !== {4'b0001, 3'b000, 2'b00}) begin
            n_fail++; $display("FAIL midreset.ctrl got busy=%b done=%b pass=%b encr=%b dec=%b mode=%b",
                               busy, done, pass, enc_reset, dec_enable, mode);
        end
        n_checks++;
        if (cipher_q !== 128'h0 || data_out !== FIPS_PT) begin
            n_fail++; $display("FAIL midreset.data got cipher=%h out=%h", cipher_q, data_out);
        end
        do_run(3'b001, FIPS_PT, FIPS_128, 1'b0, 0, "after_reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (cipher_q !== 128'h0 || done !== 1'b0 || pass !== 1'b0) begin
            n_fail++; $display("FAIL donereset got cipher=%h done=%b pass=%b want 0 0 0", cipher_q, done, pass);
        end
    endtask

    task automatic test_mismatch_restart();
        do_run(3'b001, FIPS_PT, FIPS_128, 1'b1, 0, "corrupt128");
        do_run(3'b001, FIPS_PT, FIPS_128, 1'b0, 5, "restart_pulse");
        do_run(3'b100, FIPS_PT, FIPS_256, 1'b0, 20, "pulse_in_dec");
    endtask

    task automatic test_back_to_back_random();
        logic [2:0]   ks;
        logic [127:0] pt;
        logic [127:0] ct;
        logic         bad;
        int           pa;
        for (int r = 0; r < 8; r++) begin
            ks  = 3'b001 << $urandom_range(0, 2);
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            bad = 1'($urandom_range(0, 1));
            pa  = $urandom_range(0, 20);
            do_run(ks, pt, ct, bad, pa, $sformatf("rand%0d", r));
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        key_sel = 3'b000;
        plaintext = FIPS_PT;
        test_reset();
        test_fips_runs();
        test_illegal_select();
        test_reset_mid_run();
        test_illegal_select();
        test_mismatch_restart();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
